spi_master_multi: RTL and testbench

- Parametrised SPI master, successor to the single-byte, mode-0-only master used for the RF link.
- Adds configurable word width, all four SPI modes (CPOL/CPHA), a runtime clock divider, and NUM_CS chip-selects with per-transfer selection.
- Supports burst transfers with CSN held between words.
- Sits between a host FSM (register/RF driver) and external SPI peripherals.

---
 rtl/spi_master_multi_if.sv | 33 +++
 rtl/spi_master_multi.sv | 117 +++++++++++
 tb/tb_spi_master_multi.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/spi_master_multi_if.sv
// spi_master_multi_if: host-side request/response bundle for spi_master_multi.
// Host drives start/tx_data/cs_sel/cpol/cpha/div/hold_csn (plus lsb_first when
// SPI_MASTER_LSB_FIRST_EN is defined); the SPI master returns rx_data/done/busy.
// Modports: master = host FSM side, slave = SPI master block side.
interface spi_master_multi_if #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 2,
  parameter int DIV_W  = 8
);
  localparam int CSW = NUM_CS > 1 ? $clog2(NUM_CS) : 1;
  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic [CSW-1:0]    cs_sel;
  logic              cpol;
  logic              cpha;
  logic [DIV_W-1:0]  div;
  logic              hold_csn;
  logic [DATA_W-1:0] rx_data;
  logic              done;
  logic              busy;
`ifdef SPI_MASTER_LSB_FIRST_EN
  logic              lsb_first;
  modport master (output start, tx_data, cs_sel, cpol, cpha, div, hold_csn, lsb_first,
                  input rx_data, done, busy);
  modport slave  (input start, tx_data, cs_sel, cpol, cpha, div, hold_csn, lsb_first,
                  output rx_data, done, busy);
`else
  modport master (output start, tx_data, cs_sel, cpol, cpha, div, hold_csn,
                  input rx_data, done, busy);
  modport slave  (input start, tx_data, cs_sel, cpol, cpha, div, hold_csn,
                  output rx_data, done, busy);
`endif
endinterface

// File: rtl/spi_master_multi.sv
// spi_master_multi: SPI master, DATA_W-bit words, all four CPOL/CPHA modes,
// runtime half-period divider, NUM_CS active-low chip selects, CSN hold for bursts.
// Ports: clk, rstn (async active-low), bus (spi_master_multi_if.slave host bundle),
// sclk/mosi/miso (SPI pins), csn[NUM_CS] (chip selects).
// Optional: define SPI_MASTER_LSB_FIRST_EN to add bus.lsb_first (LSB-first words).
module spi_master_multi #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 2,
  parameter int DIV_W  = 8
) (
  input  logic                clk,
  input  logic                rstn,
  spi_master_multi_if.slave   bus,
  output logic                sclk,
  output logic                mosi,
  input  logic                miso,
  output logic [NUM_CS-1:0]   csn
);
  localparam int EW = $clog2(2 * DATA_W);
  localparam logic [1:0] IDLE = 2'd0, LEAD = 2'd1, XFER = 2'd2, TRAIL = 2'd3;
  logic [1:0]        state;
  logic [DATA_W-1:0] tx_q, rx_q, rx_data, tx_in, rx_out;
  logic [DIV_W-1:0]  h_q, tmr;
  logic [EW-1:0]     edge_cnt;
  logic [NUM_CS-1:0] csn_sel;
  logic              cpol_q, cpha_q, done, accept, tick, lead_edge, last_edge, drive, sample;
`ifdef SPI_MASTER_LSB_FIRST_EN
  logic lsb_q;
  function automatic logic [DATA_W-1:0] rev(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = v[DATA_W-1-i];
    return r;
  endfunction
  // LSB-first reuses the MSB-first datapath on bit-reversed words
  assign tx_in  = bus.lsb_first ? rev(bus.tx_data) : bus.tx_data;
  assign rx_out = lsb_q ? rev(rx_q) : rx_q;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) lsb_q <= 1'b0;
    else if (accept) lsb_q <= bus.lsb_first;
`else
  assign tx_in  = bus.tx_data;
  assign rx_out = rx_q;
`endif
  // done cycle still counts as busy, so the next start lands one cycle later
  assign accept    = state == IDLE && !done && bus.start;
  assign tick      = state != IDLE && tmr == h_q - DIV_W'(1);
  assign lead_edge = !edge_cnt[0];
  assign last_edge = edge_cnt == EW'(2 * DATA_W - 1);
  assign drive     = state == XFER && tick && (cpha_q ? lead_edge : !lead_edge && !last_edge);
  assign sample    = state == XFER && tick && (cpha_q ? !lead_edge : lead_edge);
  assign bus.busy    = state != IDLE || done;
  assign bus.done    = done;
  assign bus.rx_data = rx_data;
  // out-of-range cs_sel decodes to no device selected
  always_comb
    for (int i = 0; i < NUM_CS; i++) csn_sel[i] = int'(bus.cs_sel) != i;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state    <= IDLE;
      tmr      <= '0;
      edge_cnt <= '0;
      h_q      <= DIV_W'(2);
      tx_q     <= '0;
      rx_q     <= '0;
      rx_data  <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      csn      <= '1;
      done     <= 1'b0;
    end else begin
      done <= state == TRAIL && tick;
      tmr  <= state == IDLE || tick ? '0 : tmr + DIV_W'(1);
      if (drive) begin
        mosi <= tx_q[DATA_W-1];
        tx_q <= tx_q << 1;
      end
      if (sample) rx_q <= {rx_q[DATA_W-2:0], miso};
      case (state)
        IDLE:
          if (accept) begin
            cpol_q <= bus.cpol;
            cpha_q <= bus.cpha;
            h_q    <= bus.div < DIV_W'(2) ? DIV_W'(2) : bus.div;
            sclk   <= bus.cpol;
            // cpha=0 needs the MSB on the wire before the first (sampling) edge
            mosi   <= bus.cpha ? 1'b0 : tx_in[DATA_W-1];
            tx_q   <= bus.cpha ? tx_in : tx_in << 1;
            csn    <= csn_sel;
            state  <= LEAD;
          end else begin
            sclk <= cpol_q;
            if (!bus.hold_csn) csn <= '1;
          end
        LEAD:
          if (tick) begin
            edge_cnt <= '0;
            state    <= XFER;
          end
        XFER:
          if (tick) begin
            sclk     <= !sclk;
            edge_cnt <= edge_cnt + EW'(1);
            if (last_edge) state <= TRAIL;
          end
        TRAIL:
          if (tick) begin
            rx_data <= rx_out;
            mosi    <= 1'b0;
            if (!bus.hold_csn) csn <= '1;
            state   <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_spi_master_multi.sv
// tb_spi_master_multi: scoreboard bench for spi_master_multi (DATA_W=8, NUM_CS=2).
module tb_spi_master_multi;
  localparam int DW = 8, NCS = 2, DVW = 8;
  typedef struct {
    logic [DW-1:0] rx;
    int            cyc;
    int            lat;
  } exp_t;
  logic           clk = 1'b0, rstn = 1'b0, sclk, mosi, miso, loop = 1'b1;
  logic           prev_sclk = 1'b0, glitch = 1'b0, burst_win = 1'b0;
  logic [NCS-1:0] csn;
  logic [DW-1:0]  slv = '0, slv_sh;
  int             cyc = 0, pass = 0, total = 0, tog = 0, last_t = 0, half_per = 0;
  int             rises = 0, sbase = 0;
  exp_t           q[$];
  exp_t           e_mon;
  spi_master_multi_if #(.DATA_W(DW), .NUM_CS(NCS), .DIV_W(DVW)) bus();
  spi_master_multi #(.DATA_W(DW), .NUM_CS(NCS), .DIV_W(DVW)) dut (
    .clk(clk), .rstn(rstn), .bus(bus), .sclk(sclk), .mosi(mosi), .miso(miso), .csn(csn)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  // slave presents its word MSB first and advances after each rising SCLK
  always @(posedge sclk) rises++;
  assign slv_sh = slv << (rises - sbase);
  assign miso   = loop ? mosi : slv_sh[DW-1];
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) pass++;
    else $display("FAIL %s got=%0h expected=%0h", name, got, exp);
  endtask
  always @(negedge clk) begin
    if (sclk !== prev_sclk) begin
      half_per = cyc - last_t;
      last_t   = cyc;
      tog++;
    end
    prev_sclk = sclk;
    if (burst_win && !bus.done && csn !== 2'b01) glitch = 1'b1;
    if (bus.done) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_done rx_data=%0h expected no done", bus.rx_data);
      end else begin
        e_mon = q.pop_front();
        chk("rx_data", 32'(bus.rx_data), 32'(e_mon.rx));
        chk("done_latency", cyc - e_mon.cyc, e_mon.lat);
      end
    end
  end
  task automatic issue(input logic [DW-1:0] tx, input logic cs, input logic pol, input logic pha,
                       input logic [DVW-1:0] dv, input logic hold, input logic lp,
                       input logic [DW-1:0] sv, input logic [DW-1:0] exp_rx);
    int h = dv < 2 ? 2 : int'(dv);
    @(posedge clk); #1;
    bus.tx_data  = tx;
    bus.cs_sel   = cs;
    bus.cpol     = pol;
    bus.cpha     = pha;
    bus.div      = dv;
    bus.hold_csn = hold;
    bus.start    = 1'b1;
    loop         = lp;
    q.push_back('{exp_rx, cyc, 1 + h * (2 * DW + 2)});
    @(posedge clk); #1;
    bus.start = 1'b0;
    slv       = sv;
    sbase     = rises;
  endtask
  task automatic wait_done(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 3000);
    if (!bus.done) begin
      total++;
      $display("FAIL %s timeout got=no_done expected=done", name);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int r0, t0, n;
    bus.start = 1'b0; bus.tx_data = '0; bus.cs_sel = '0; bus.cpol = 1'b0;
    bus.cpha = 1'b0; bus.div = 8'd2; bus.hold_csn = 1'b0;
`ifdef SPI_MASTER_LSB_FIRST_EN
    bus.lsb_first = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'(1'b0));
    chk("rst_done", 32'(bus.done), 32'(1'b0));
    chk("rst_rx", 32'(bus.rx_data), 32'(8'h00));
    chk("rst_mosi", 32'(mosi), 32'(1'b0));
    chk("rst_csn", 32'(csn), 32'(2'b11));
    chk("rst_sclk", 32'(sclk), 32'(1'b0));
    rstn = 1'b1;
    // mode 0 loopback
    issue(8'hA5, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0, 1'b1, 8'h00, 8'hA5);
    r0 = rises;
    chk("m0_csn_sel", 32'(csn), 32'(2'b10));
    chk("m0_busy", 32'(bus.busy), 32'(1'b1));
    wait_done("m0");
    chk("m0_sclk_rises", rises - r0, 8);
    chk("m0_csn_release", 32'(csn), 32'(2'b11));
    // mode 3 with slave returning 0xC3
    issue(8'h3C, 1'b0, 1'b1, 1'b1, 8'd2, 1'b0, 1'b0, 8'hC3, 8'hC3);
    chk("m3_sclk_high", 32'(sclk), 32'(1'b1));
    wait_done("m3");
    chk("m3_sclk_idle", 32'(sclk), 32'(1'b1));
    // mode 1 loopback, longer half-period
    issue(8'h5A, 1'b0, 1'b0, 1'b1, 8'd3, 1'b0, 1'b1, 8'h00, 8'h5A);
    wait_done("m1");
    // burst on cs 1, csn held across words
    issue(8'h11, 1'b1, 1'b0, 1'b0, 8'd2, 1'b1, 1'b1, 8'h00, 8'h11);
    burst_win = 1'b1;
    wait_done("burst1");
    issue(8'h22, 1'b1, 1'b0, 1'b0, 8'd2, 1'b1, 1'b1, 8'h00, 8'h22);
    wait_done("burst2");
    issue(8'h33, 1'b1, 1'b0, 1'b0, 8'd2, 1'b0, 1'b1, 8'h00, 8'h33);
    wait_done("burst3");
    burst_win = 1'b0;
    chk("burst_no_glitch", 32'(glitch), 32'(1'b0));
    chk("burst_csn_release", 32'(csn), 32'(2'b11));
    // div=0 clamps to 2; a start while busy must be ignored
    issue(8'h69, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'h00, 8'h69);
    repeat (10) @(posedge clk);
    #1;
    chk("busy_mid", 32'(bus.busy), 32'(1'b1));
    bus.start = 1'b1; bus.tx_data = 8'hFF; bus.div = 8'd5; bus.cpha = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done("busy_start");
    chk("half_period", half_per, 2);
    repeat (80) @(negedge clk);
    chk("ignored_start_no_done", q.size(), 0);
    // async reset mid-word
    issue(8'hC6, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0, 1'b1, 8'h00, 8'hC6);
    t0 = tog;
    n = 0;
    while (tog - t0 < 5 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("reached_edge5", 32'(tog - t0 >= 5), 32'(1'b1));
    #1 rstn = 1'b0;
    #1;
    chk("arst_csn", 32'(csn), 32'(2'b11));
    chk("arst_sclk", 32'(sclk), 32'(1'b0));
    chk("arst_busy", 32'(bus.busy), 32'(1'b0));
    chk("arst_rx", 32'(bus.rx_data), 32'(8'h00));
    q.delete();
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (50) @(negedge clk);
    issue(8'h96, 1'b1, 1'b0, 1'b0, 8'd2, 1'b0, 1'b1, 8'h00, 8'h96);
    chk("post_rst_csn", 32'(csn), 32'(2'b01));
    wait_done("post_rst");
`ifdef SPI_MASTER_LSB_FIRST_EN
    bus.lsb_first = 1'b1;
    issue(8'h01, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0, 8'h01, 8'h80);
    chk("lsb_first_mosi", 32'(mosi), 32'(1'b1));
    wait_done("lsb");
    bus.lsb_first = 1'b0;
`endif
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
